// File: rtl/sent_pkg.sv
// Shared SENT CRC4 definitions: polynomial, default seed, engine FSM states, length-port width.
package sent_pkg;

  localparam logic [3:0] CRC4_POLY     = 4'b1101;
  localparam logic [3:0] CRC4_SEED_DEF = 4'h5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    AUG  = 2'd2,
    DONE = 2'd3
  } sent_crc_state_t;

  // Width of a nibble-count field able to hold 0..n.
  function automatic int unsigned len_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sent_crc_engine_if.sv
// Request/ack bus between the SENT frame builder (master) and the CRC engine (slave).
// SENT_CRC_CHECK_EN adds the expected-CRC input and the CRC-mismatch result.
interface sent_crc_engine_if
  import sent_pkg::*;
#(
  parameter int unsigned NIBBLE_MAX = 6
) ();
  localparam int unsigned LW = len_width(NIBBLE_MAX);

  logic                    crc_req;
  logic                    crc_mode;
  logic [LW-1:0]           frame_len;
  logic [4*NIBBLE_MAX-1:0] frame_data;
  logic                    busy;
  logic                    crc_ack;
  logic [3:0]              crc;
  logic                    len_err;
`ifdef SENT_CRC_CHECK_EN
  logic [3:0]              crc_exp;
  logic                    crc_err;

  modport master (output crc_req, crc_mode, frame_len, frame_data, crc_exp,
                  input  busy, crc_ack, crc, len_err, crc_err);
  modport slave  (input  crc_req, crc_mode, frame_len, frame_data, crc_exp,
                  output busy, crc_ack, crc, len_err, crc_err);
`else
  modport master (output crc_req, crc_mode, frame_len, frame_data,
                  input  busy, crc_ack, crc, len_err);
  modport slave  (input  crc_req, crc_mode, frame_len, frame_data,
                  output busy, crc_ack, crc, len_err);
`endif

endinterface

// File: rtl/sent_crc4_nibble.sv
// Combinational fold of one data nibble (MSB first) into a CRC4 register; shared with the RX frame checker.
module sent_crc4_nibble
  import sent_pkg::*;
(
  input  logic [3:0] crc_in,
  input  logic [3:0] nibble,
  output logic [3:0] crc_next_c
);

  logic [3:0] d;

  always_comb begin
    crc_next_c = crc_in;
    d          = nibble;
    for (int i = 0; i < 4; i++) begin
      crc_next_c = {crc_next_c[2:0], 1'b0} ^ ({4{crc_next_c[3] ^ d[3]}} & CRC4_POLY);
      d          = d << 1;
    end
  end

endmodule

// File: rtl/sent_crc_engine.sv
// Nibble-serial CRC4 engine for SENT fast-channel frames, one nibble per cycle, req/ack result.
// Define SENT_CRC_CHECK_EN to compare the result against a caller-supplied expected CRC.
module sent_crc_engine
  import sent_pkg::*;
#(
  parameter int unsigned NIBBLE_MAX = 6,
  parameter logic [3:0]  CRC_SEED   = CRC4_SEED_DEF
) (
  input logic              clk,
  input logic              rst_n,
  sent_crc_engine_if.slave bus
);

  localparam int unsigned LW = len_width(NIBBLE_MAX);
  localparam int unsigned DW = 4 * NIBBLE_MAX;

  sent_crc_state_t state, state_d;
  logic [DW-1:0]   shreg, shreg_d;
  logic [LW-1:0]   len_r, len_d, cnt, cnt_d;
  logic            mode_r, mode_d, lerr_r, lerr_d;
  logic [3:0]      c, c_d, fold_in, fold_out;
  logic            busy_d, ack_d, len_err_d;
  logic [3:0]      crc_d;
`ifdef SENT_CRC_CHECK_EN
  logic [3:0]      exp_r, exp_d;
  logic            crc_err_d;
`endif

  // AUG folds the appended zero nibble of recommended mode.
  assign fold_in = (state == AUG) ? 4'h0 : shreg[DW-1 -: 4];

  sent_crc4_nibble u_fold (
    .crc_in     (c),
    .nibble     (fold_in),
    .crc_next_c (fold_out)
  );

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    len_d     = len_r;
    cnt_d     = cnt;
    mode_d    = mode_r;
    lerr_d    = lerr_r;
    c_d       = c;
    busy_d    = 1'b0;
    ack_d     = 1'b0;
    crc_d     = bus.crc;
    len_err_d = bus.len_err;
`ifdef SENT_CRC_CHECK_EN
    exp_d     = exp_r;
    crc_err_d = bus.crc_err;
`endif
    case (state)
      IDLE: begin
        // busy is still high in the ack cycle, which blocks a request there
        if (bus.crc_req && !bus.busy) begin
          shreg_d = bus.frame_data;
          len_d   = bus.frame_len;
          mode_d  = bus.crc_mode;
          c_d     = CRC_SEED;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SENT_CRC_CHECK_EN
          exp_d   = bus.crc_exp;
`endif
          if ((bus.frame_len == '0) || (bus.frame_len > LW'(NIBBLE_MAX))) begin
            lerr_d  = 1'b1;
            state_d = DONE;
          end else begin
            lerr_d  = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        busy_d  = 1'b1;
        c_d     = fold_out;
        shreg_d = shreg << 4;
        cnt_d   = cnt + LW'(1);
        if (cnt_d == len_r) state_d = mode_r ? AUG : DONE;
      end
      AUG: begin
        busy_d  = 1'b1;
        c_d     = fold_out;
        state_d = DONE;
      end
      DONE: begin
        busy_d    = 1'b1;
        ack_d     = 1'b1;
        crc_d     = c;
        len_err_d = lerr_r;
`ifdef SENT_CRC_CHECK_EN
        crc_err_d = lerr_r | (c != exp_r);
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      len_r       <= '0;
      cnt         <= '0;
      mode_r      <= 1'b0;
      lerr_r      <= 1'b0;
      c           <= 4'h0;
      bus.busy    <= 1'b0;
      bus.crc_ack <= 1'b0;
      bus.crc     <= 4'h0;
      bus.len_err <= 1'b0;
`ifdef SENT_CRC_CHECK_EN
      exp_r       <= 4'h0;
      bus.crc_err <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      len_r       <= len_d;
      cnt         <= cnt_d;
      mode_r      <= mode_d;
      lerr_r      <= lerr_d;
      c           <= c_d;
      bus.busy    <= busy_d;
      bus.crc_ack <= ack_d;
      bus.crc     <= crc_d;
      bus.len_err <= len_err_d;
`ifdef SENT_CRC_CHECK_EN
      exp_r       <= exp_d;
      bus.crc_err <= crc_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sent_crc_engine.sv
// Scoreboard bench for sent_crc_engine: stimulus pushes expected results, a negedge monitor checks each ack.
module tb_sent_crc_engine;
  import sent_pkg::*;

  localparam int unsigned NM = 6;
  localparam int unsigned LW = len_width(NM);
  localparam int unsigned DW = 4 * NM;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sent_crc_engine_if #(.NIBBLE_MAX(NM)) bus ();

  sent_crc_engine #(.NIBBLE_MAX(NM), .CRC_SEED(4'h5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] crc;
    logic       len_err;
    logic       crc_err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Bit-serial reference: x^4+x^3+x^2+1, MSB first, seed 5, optional trailing zero nibble.
  function automatic logic [3:0] crc_ref(input logic [DW-1:0] data, input int len, input logic mode);
    logic [3:0]    c;
    logic [DW-1:0] d;
    logic          b;
    int            nb;
    c = 4'h5;
    d = data;
    if (len == 0 || len > NM) return c;
    nb = len + (mode ? 1 : 0);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = (k < len) ? d[DW-1] : 1'b0;
        if (k < len) d = d << 1;
        c = {c[2:0], 1'b0} ^ ((c[3] ^ b) ? 4'b1101 : 4'b0000);
      end
    end
    return c;
  endfunction

  // Called at posedge+1; waits for the engine to be free, then issues one request.
  task automatic send(input logic mode, input int len, input logic [DW-1:0] data,
                      input logic [3:0] ecrc, input logic [3:0] cexp);
    exp_t e;
    int   g;
    g = 0;
    while (bus.busy !== 1'b0 && g < 50) begin @(posedge clk); #1; g++; end
    if (bus.busy !== 1'b0) begin
      n_chk++;
      $display("FAIL send_wait_busy: busy=%0b still high after %0d cycles", bus.busy, g);
      return;
    end
    bus.crc_req    = 1'b1;
    bus.crc_mode   = mode;
    bus.frame_len  = LW'(len);
    bus.frame_data = data;
`ifdef SENT_CRC_CHECK_EN
    bus.crc_exp    = cexp;
`endif
    @(posedge clk); #1;
    bus.crc_req = 1'b0;
    e.len_err = (len == 0 || len > NM);
    e.crc     = ecrc;
    e.crc_err = e.len_err | (ecrc != cexp);
    e.lat     = e.len_err ? 1 : len + (mode ? 1 : 0) + 1;
    e.acc     = cyc;
    sb.push_back(e);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) begin
      n_chk++;
      $display("FAIL wait_idle_timeout: pending=%0d busy=%0b want pending=0 busy=0", sb.size(), bus.busy);
    end
  endtask

  // Monitor: every ack pops one expectation; outside ack, crc/len_err must hold.
  logic [3:0] held_crc = 4'h0;
  logic       held_le  = 1'b0;
  exp_t       m;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_crc = 4'h0;
      held_le  = 1'b0;
    end else if (bus.crc_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ack: got ack with crc=%0h, want no ack", bus.crc);
      end else begin
        m = sb.pop_front();
        chk("crc", 32'(bus.crc), 32'(m.crc));
        chk("len_err", 32'(bus.len_err), 32'(m.len_err));
        chk("latency", 32'(cyc - m.acc), 32'(m.lat));
        chk("busy_in_ack", 32'(bus.busy), 32'd1);
`ifdef SENT_CRC_CHECK_EN
        chk("crc_err", 32'(bus.crc_err), 32'(m.crc_err));
`endif
      end
      held_crc = bus.crc;
      held_le  = bus.len_err;
    end else begin
      chk("result_held", {27'd0, bus.len_err, bus.crc}, {27'd0, held_le, held_crc});
    end
  end

  logic [DW-1:0] rd;
  logic          rm;
  int            rl;

  initial begin
    bus.crc_req    = 1'b0;
    bus.crc_mode   = 1'b0;
    bus.frame_len  = '0;
    bus.frame_data = '0;
`ifdef SENT_CRC_CHECK_EN
    bus.crc_exp    = 4'h0;
`endif
    #1 rst_n = 1'b0;
    #20;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.crc_ack), 32'd0);
    chk("rst_crc", 32'(bus.crc), 32'd0);
    chk("rst_len_err", 32'(bus.len_err), 32'd0);
`ifdef SENT_CRC_CHECK_EN
    chk("rst_crc_err", 32'(bus.crc_err), 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed vectors
    send(1'b0, 1, 24'h000000, 4'h3, 4'h3);
    send(1'b1, 1, 24'h000000, 4'hA, 4'hA);
    send(1'b0, 1, 24'h500000, 4'h0, 4'h0);
    send(1'b0, 2, 24'h000000, 4'hA, 4'hA);
    send(1'b0, 0, 24'h123456, 4'h5, 4'h5);
    send(1'b1, 7, 24'h123456, 4'h5, 4'h5);
    send(1'b0, 1, 24'h000000, 4'h3, 4'h4);
    wait_idle();

    // A request pulsed while busy must be dropped
    send(1'b0, 3, 24'hABC000, crc_ref(24'hABC000, 3, 1'b0), crc_ref(24'hABC000, 3, 1'b0));
    @(posedge clk); #1;
    bus.crc_req    = 1'b1;
    bus.frame_len  = LW'(1);
    bus.frame_data = 24'hF00000;
    @(posedge clk); #1;
    bus.crc_req = 1'b0;
    wait_idle();

    // Leave a non-zero result, then abort a 6-nibble frame in its 3rd CALC cycle
    send(1'b1, 1, 24'h000000, 4'hA, 4'hA);
    wait_idle();
    bus.crc_req    = 1'b1;
    bus.crc_mode   = 1'b0;
    bus.frame_len  = LW'(6);
    bus.frame_data = 24'h13579B;
    @(posedge clk); #1;
    bus.crc_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ack", 32'(bus.crc_ack), 32'd0);
    chk("abort_crc", 32'(bus.crc), 32'd0);
    chk("abort_len_err", 32'(bus.len_err), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(1'b0, 1, 24'h500000, 4'h0, 4'h0);
    wait_idle();

    // Random frames of length 6 and 3 against the reference model
    for (int i = 0; i < 40; i++) begin
      rd = DW'({$urandom(), $urandom()});
      rm = 1'($urandom_range(0, 1));
      rl = (i % 2 == 0) ? 6 : 3;
      send(rm, rl, rd, crc_ref(rd, rl, rm), crc_ref(rd, rl, rm));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
